// File: rtl/dechannelizer_n.sv
// Serialises one captured sample per enabled channel into an Avalon-ST packet; first beat 1 cycle after the in_valid edge.
// out_valid never depends on out_ready; beats hold while stalled; edges during a packet are dropped and counted.
module dechannelizer_n #(
  parameter int DATA_WIDTH = 24,
  parameter int CHANNELS   = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic                           in_valid,
  input  logic [CHANNELS-1:0]            ch_enable,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [3:0]                     out_channel,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_sop,
  output logic                           out_eop,
  output logic                           overrun,
  output logic [CNT_WIDTH-1:0]           overrun_cnt
);

  generate
    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
      $error("dechannelizer_n: CHANNELS must be in 1..16");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_SEND} state_t;

  function automatic logic [3:0] lowest_from(input logic [CHANNELS-1:0] m, input int from);
    logic [3:0] r;
    r = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (k >= from && m[k]) r = 4'(k);
    end
    return r;
  endfunction

  function automatic logic [3:0] highest(input logic [CHANNELS-1:0] m);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (m[k]) r = 4'(k);
    end
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pick(input logic [CHANNELS*DATA_WIDTH-1:0] d,
                                                 input logic [3:0] idx);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (4'(k) == idx) r = d[k*DATA_WIDTH +: DATA_WIDTH];
    end
    return r;
  endfunction

  state_t                         state_q, state_d;
  logic                           in_valid_d_q, in_valid_d_d;
  logic [CHANNELS*DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [CHANNELS-1:0]            hold_mask_q, hold_mask_d;
  logic [3:0]                     ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]          out_data_q, out_data_d;
  logic [3:0]                     out_channel_q, out_channel_d;
  logic                           out_valid_q, out_valid_d;
  logic                           out_sop_q, out_sop_d;
  logic                           out_eop_q, out_eop_d;
  logic                           overrun_q, overrun_d;
  logic [CNT_WIDTH-1:0]           overrun_cnt_q, overrun_cnt_d;
  logic                           in_edge;
  logic [3:0]                     nxt_ptr;

  assign in_edge = in_valid & ~in_valid_d_q;

  always_comb begin
    state_d       = state_q;
    in_valid_d_d  = in_valid;
    hold_data_d   = hold_data_q;
    hold_mask_d   = hold_mask_q;
    ptr_d         = ptr_q;
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    out_valid_d   = out_valid_q;
    out_sop_d     = out_sop_q;
    out_eop_d     = out_eop_q;
    overrun_d     = 1'b0;
    overrun_cnt_d = overrun_cnt_q;
    nxt_ptr       = '0;

    case (state_q)
      S_IDLE: begin
        if (in_edge) begin
          hold_data_d = in_data;
          hold_mask_d = ch_enable;
          // The first beat is built straight from the inputs so it appears the cycle after capture.
          if (|ch_enable) begin
            nxt_ptr       = lowest_from(ch_enable, 0);
            state_d       = S_SEND;
            ptr_d         = nxt_ptr;
            out_valid_d   = 1'b1;
            out_data_d    = pick(in_data, nxt_ptr);
            out_channel_d = nxt_ptr;
            out_sop_d     = 1'b1;
            out_eop_d     = (nxt_ptr == highest(ch_enable));
          end
        end
      end
      S_SEND: begin
        if (out_ready) begin
          if (out_eop_q) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_sop_d   = 1'b0;
            out_eop_d   = 1'b0;
          end else begin
            nxt_ptr       = lowest_from(hold_mask_q, int'(ptr_q) + 1);
            ptr_d         = nxt_ptr;
            out_data_d    = pick(hold_data_q, nxt_ptr);
            out_channel_d = nxt_ptr;
            out_sop_d     = 1'b0;
            out_eop_d     = (nxt_ptr == highest(hold_mask_q));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (in_edge && state_q != S_IDLE) begin
      overrun_d = 1'b1;
      if (overrun_cnt_q != {CNT_WIDTH{1'b1}}) overrun_cnt_d = overrun_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      in_valid_d_q  <= 1'b0;
      hold_data_q   <= '0;
      hold_mask_q   <= '0;
      ptr_q         <= '0;
      out_data_q    <= '0;
      out_channel_q <= '0;
      out_valid_q   <= 1'b0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      overrun_q     <= 1'b0;
      overrun_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      in_valid_d_q  <= in_valid_d_d;
      hold_data_q   <= hold_data_d;
      hold_mask_q   <= hold_mask_d;
      ptr_q         <= ptr_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      out_valid_q   <= out_valid_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
      overrun_q     <= overrun_d;
      overrun_cnt_q <= overrun_cnt_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_channel = out_channel_q;
  assign out_valid   = out_valid_q;
  assign out_sop     = out_sop_q;
  assign out_eop     = out_eop_q;
  assign overrun     = overrun_q;
  assign overrun_cnt = overrun_cnt_q;

endmodule
